hdmi_vram_arbiter: RTL
======================

// Module: hdmi_vram_arbiter
// PURPOSE
//  Shares the single-port VRAM/palette BRAM of the HDMI text controller between two requesters.
//  - Display fetch: hard deadline, fixed top priority.
//  - Host queue: AXI accesses already synchronised into pixel_clk; buffered in a small FIFO.
//  - Read and write acks return in order, at fixed BRAM latency, tagged by owner.
//  Sits between the AXI slave CDC stage / text draw pipeline and the BRAM primitive.
// PARAMETERS
//  ADDR_W     10   BRAM word address width
//  DATA_W     32   BRAM data width (byte strobes = DATA_W/8)
//  VRAM_WORDS 608  valid word range 0..VRAM_WORDS-1 (VRAM + palette + control)
//  HQ_DEPTH   4    host request FIFO depth, power of 2, >=2
//  BRAM_LAT   2    BRAM read latency in cycles, 1..3
// PORTS
//  pixel_clk      in   1        clock
//  arstn          in   1        synchronous active-low reset
//  disp_req       in   1        display fetch request this cycle
//  disp_addr      in   ADDR_W   display word address
//  disp_rvalid    out  1        display read data valid
//  disp_rdata     out  DATA_W   display read data
//  host_req_valid in   1        host request valid
//  host_req_ready out  1        FIFO can accept
//  host_we        in   1        1=write, 0=read
//  host_addr      in   ADDR_W   host word address
//  host_wdata     in   DATA_W   write data
//  host_wstrb     in   DATA_W/8 byte strobes
//  host_rsp_valid out  1        one-cycle ack pulse (read or write); no backpressure
//  host_rsp_rdata out  DATA_W   read data (0 for write acks)
//  bram_en        out  1        BRAM enable
//  bram_we        out  DATA_W/8 BRAM byte write enables
//  bram_addr      out  ADDR_W   BRAM address
//  bram_wdata     out  DATA_W   BRAM write data
//  bram_rdata     in   DATA_W   BRAM read data
//  stat_host_stall out 16       stall counter (see CONFIGURATION)
//  stat_disp_cnt   out 16       display grant counter (see CONFIGURATION)
// BEHAVIOUR
//  - Reset:
//    - All outputs 0; host_req_ready=1.
//    - FIFO emptied; tag pipeline cleared; in-flight responses dropped, never emitted.
//  - Slot FSM, one grant per cycle. States IDLE, DISP, HOST, registered into the bram_* outputs:
//    - disp_req=1 -> DISP (wins every collision).
//    - else FIFO non-empty -> HOST.
//    - else IDLE (bram_en=0).
//  - Host path:
//    - Push when host_req_valid && host_req_ready.
//    - host_req_ready = !full. It is computed from occupancy only; no pass-through when full,
//      even if a pop occurs in the same cycle.
//    - Minimum latency push -> BRAM issue is 1 cycle. A push into an empty FIFO issues on the next cycle.
//  - Tag pipeline: BRAM_LAT+1 stages of {valid, owner, is_write, in_range}.
//    - disp_rvalid / host_rsp_valid assert exactly BRAM_LAT+1 cycles after the grant cycle.
//  - Out of range (addr >= VRAM_WORDS):
//    - Writes drive bram_we=0 but are still acked.
//    - Reads return 0 but are still acked.
//    - Address does not wrap.
//  - Writes: bram_we = host_wstrb for in-range writes; read-modify-write is not used.
//  - Ordering: host responses follow FIFO order. A host read after a host write to the same
//    address returns the new data (single port, in order).
//  - Display requests are never stalled; disp_req may assert back-to-back every cycle.
//    The host then starves, which is expected during active video.
// CONFIGURATION
//  Macro VRAM_ARB_STATS_EN.
//  - Defined:
//    - stat_host_stall increments each cycle the FIFO is non-empty but DISP is granted.
//    - stat_disp_cnt increments each DISP grant.
//    - Both are 16-bit, saturate at 16'hFFFF, and clear on reset.
//  - Undefined: both ports are tied to 0; no counter logic.
// STRUCTURE
//  Package hdmi_vram_pkg:
//  - typedef enum logic [1:0] {SLOT_IDLE, SLOT_DISP, SLOT_HOST} slot_e.
//  - typedef struct host_req_t {we, addr, wdata, wstrb}.
//  - typedef struct tag_t {vld, owner, is_write, in_range}.
//  - localparam VRAM_WORDS_DEF.
//  Sub-module hdmi_vram_host_fifo:
//  - Synchronous FIFO of host_req_t with full/empty outputs.
//  - Pointers are ADDR-width log2(HQ_DEPTH)+1.
// TESTING
//  1. Host write addr 5, data 32'h70207620, wstrb F, no disp_req
//     -> bram_we=F at addr 5; host_rsp_valid after BRAM_LAT+1 grant cycles.
//     Readback of addr 5 -> 32'h70207620.
//  2. disp_req held 10 cycles with 2 host writes queued
//     -> 10 DISP grants, host issues in the 2 following cycles.
//     With the macro, stat_host_stall=10.
//  3. Push 5 requests with no pops (disp_req=1)
//     -> host_req_ready=0 after the 4th; the 5th is held until a pop, never lost.
//  4. Host write wstrb=4'b0010, data 32'h0000AB00 over 32'hFFFFFFFF
//     -> readback 32'hFFFFABFF.
//  5. Host read addr 700 (>= VRAM_WORDS) -> host_rsp_valid with rdata 0.
//     Host write addr 700 -> bram_we=0, ack still given.
//  6. arstn low while 2 reads are in flight -> no host_rsp_valid emitted.
//     FIFO empty, host_req_ready=1 on the first cycle after reset.

Source files
------------

// File: rtl/hdmi_vram_pkg.sv
// Shared types and defaults for the HDMI VRAM/palette BRAM arbiter.
// The host request struct is sized by ADDR_W_DEF/DATA_W_DEF, so the arbiter's widths must match them.
package hdmi_vram_pkg;

  localparam int ADDR_W_DEF     = 10;
  localparam int DATA_W_DEF     = 32;
  localparam int VRAM_WORDS_DEF = 608;

  typedef enum logic [1:0] {SLOT_IDLE, SLOT_DISP, SLOT_HOST} slot_e;
  typedef enum logic {OWN_DISP, OWN_HOST} owner_e;

  typedef struct packed {
    logic                    we;
    logic [ADDR_W_DEF-1:0]   addr;
    logic [DATA_W_DEF-1:0]   wdata;
    logic [DATA_W_DEF/8-1:0] wstrb;
  } host_req_t;

  typedef struct packed {
    logic   vld;
    owner_e owner;
    logic   is_write;
    logic   in_range;
  } tag_t;

  function automatic logic addr_in_range(input logic [ADDR_W_DEF-1:0] addr, input int words);
    logic [31:0] a32;
    a32 = 32'(addr);
    return a32 < 32'(words);
  endfunction

endpackage

// File: rtl/hdmi_vram_host_fifo.sv
// Small synchronous FIFO buffering host BRAM requests; pointers carry an extra wrap bit
// so that full and empty can be told apart.
module hdmi_vram_host_fifo
  import hdmi_vram_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      pixel_clk,
  input  logic      arstn,
  input  logic      push,
  input  logic      pop,
  input  host_req_t wr_data,
  output host_req_t rd_data,
  output logic      full,
  output logic      empty
);

  localparam int PW = $clog2(DEPTH) + 1;

  host_req_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
  assign rd_data = mem[rd_ptr[PW-2:0]];

  always_ff @(posedge pixel_clk) begin
    if (!arstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately left out of reset; only the pointers decide what is valid.
  always_ff @(posedge pixel_clk) begin
    if (push && !full) mem[wr_ptr[PW-2:0]] <= wr_data;
  end

endmodule

// File: rtl/hdmi_vram_arbiter.sv
// Single-port VRAM/palette BRAM arbiter: display fetch has fixed priority, host requests are queued.
// Define VRAM_ARB_STATS_EN to build the host-stall and display-grant counters.
module hdmi_vram_arbiter
  import hdmi_vram_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int VRAM_WORDS = VRAM_WORDS_DEF,
  parameter int HQ_DEPTH   = 4,
  parameter int BRAM_LAT   = 2
) (
  input  logic                pixel_clk,
  input  logic                arstn,
  input  logic                disp_req,
  input  logic [ADDR_W-1:0]   disp_addr,
  output logic                disp_rvalid,
  output logic [DATA_W-1:0]   disp_rdata,
  input  logic                host_req_valid,
  output logic                host_req_ready,
  input  logic                host_we,
  input  logic [ADDR_W-1:0]   host_addr,
  input  logic [DATA_W-1:0]   host_wdata,
  input  logic [DATA_W/8-1:0] host_wstrb,
  output logic                host_rsp_valid,
  output logic [DATA_W-1:0]   host_rsp_rdata,
  output logic                bram_en,
  output logic [DATA_W/8-1:0] bram_we,
  output logic [ADDR_W-1:0]   bram_addr,
  output logic [DATA_W-1:0]   bram_wdata,
  input  logic [DATA_W-1:0]   bram_rdata,
  output logic [15:0]         stat_host_stall,
  output logic [15:0]         stat_disp_cnt
);

  host_req_t fifo_wr;
  host_req_t fifo_head;
  logic      fifo_full;
  logic      fifo_empty;
  logic      fifo_push;
  logic      fifo_pop;
  logic      head_in_range;

  slot_e     slot_q;
  logic      s0_write;
  logic      s0_in_range;
  tag_t      tag_s0;
  tag_t      tag_last;
  tag_t      tag_pipe [BRAM_LAT];

  assign fifo_wr        = '{we: host_we, addr: host_addr, wdata: host_wdata, wstrb: host_wstrb};
  assign fifo_push      = host_req_valid && !fifo_full;
  assign fifo_pop       = !disp_req && !fifo_empty;
  // Ready depends on occupancy alone, so a full FIFO never accepts even while popping.
  assign host_req_ready = !fifo_full;
  assign head_in_range  = addr_in_range(fifo_head.addr, VRAM_WORDS);

  hdmi_vram_host_fifo #(.DEPTH(HQ_DEPTH)) u_host_fifo (
    .pixel_clk (pixel_clk),
    .arstn     (arstn),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .wr_data   (fifo_wr),
    .rd_data   (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // One grant per cycle; the chosen requester's access is registered straight onto the BRAM pins.
  always_ff @(posedge pixel_clk) begin
    if (!arstn) begin
      slot_q      <= SLOT_IDLE;
      bram_en     <= 1'b0;
      bram_we     <= '0;
      bram_addr   <= '0;
      bram_wdata  <= '0;
      s0_write    <= 1'b0;
      s0_in_range <= 1'b0;
    end else if (disp_req) begin
      slot_q      <= SLOT_DISP;
      bram_en     <= 1'b1;
      bram_we     <= '0;
      bram_addr   <= disp_addr;
      bram_wdata  <= '0;
      s0_write    <= 1'b0;
      s0_in_range <= addr_in_range(disp_addr, VRAM_WORDS);
    end else if (!fifo_empty) begin
      slot_q      <= SLOT_HOST;
      bram_en     <= 1'b1;
      bram_we     <= (fifo_head.we && head_in_range) ? fifo_head.wstrb : '0;
      bram_addr   <= fifo_head.addr;
      bram_wdata  <= fifo_head.wdata;
      s0_write    <= fifo_head.we;
      s0_in_range <= head_in_range;
    end else begin
      slot_q      <= SLOT_IDLE;
      bram_en     <= 1'b0;
      bram_we     <= '0;
      bram_addr   <= '0;
      bram_wdata  <= '0;
      s0_write    <= 1'b0;
      s0_in_range <= 1'b0;
    end
  end

  always_comb begin
    tag_s0 = '{vld:      (slot_q != SLOT_IDLE),
               owner:    (slot_q == SLOT_HOST) ? OWN_HOST : OWN_DISP,
               is_write: s0_write,
               in_range: s0_in_range};
  end

  assign tag_last = tag_pipe[BRAM_LAT-1];

  // The tag leaving the pipeline lines up with bram_rdata for the access it describes.
  always_ff @(posedge pixel_clk) begin
    if (!arstn) begin
      for (int i = 0; i < BRAM_LAT; i++) tag_pipe[i] <= '0;
      disp_rvalid    <= 1'b0;
      disp_rdata     <= '0;
      host_rsp_valid <= 1'b0;
      host_rsp_rdata <= '0;
    end else begin
      tag_pipe[0] <= tag_s0;
      for (int i = 1; i < BRAM_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
      disp_rvalid    <= tag_last.vld && (tag_last.owner == OWN_DISP);
      disp_rdata     <= (tag_last.vld && (tag_last.owner == OWN_DISP) && tag_last.in_range)
                        ? bram_rdata : '0;
      host_rsp_valid <= tag_last.vld && (tag_last.owner == OWN_HOST);
      host_rsp_rdata <= (tag_last.vld && (tag_last.owner == OWN_HOST) && !tag_last.is_write
                         && tag_last.in_range) ? bram_rdata : '0;
    end
  end

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] stall_q;
  logic [15:0] disp_cnt_q;

  always_ff @(posedge pixel_clk) begin
    if (!arstn) begin
      stall_q    <= '0;
      disp_cnt_q <= '0;
    end else begin
      if (disp_req && !fifo_empty && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
      if (disp_req && (disp_cnt_q != 16'hFFFF))             disp_cnt_q <= disp_cnt_q + 16'd1;
    end
  end

  assign stat_host_stall = stall_q;
  assign stat_disp_cnt   = disp_cnt_q;
`else
  assign stat_host_stall = 16'd0;
  assign stat_disp_cnt   = 16'd0;
`endif

endmodule
